// File: rtl/srai_accel_ctrl_regs_if.sv
// AXI-Lite host interface for the SRAI accelerator control block.
//   slave  : register-file side (accepts AW/W/AR, drives B/R)
//   master : host side
interface srai_accel_AXI_LITE_intfc #(
  parameter int AXI_LITE_AW = 32,
  parameter int AXI_LITE_DW = 32
);
  logic [AXI_LITE_AW-1:0]   AXI_LITE_awaddr;
  logic                     AXI_LITE_awvalid;
  logic                     AXI_LITE_awready;
  logic [AXI_LITE_DW-1:0]   AXI_LITE_wdata;
  logic [AXI_LITE_DW/8-1:0] AXI_LITE_wstrb;
  logic                     AXI_LITE_wvalid;
  logic                     AXI_LITE_wready;
  logic [1:0]               AXI_LITE_bresp;
  logic                     AXI_LITE_bvalid;
  logic                     AXI_LITE_bready;
  logic [AXI_LITE_AW-1:0]   AXI_LITE_araddr;
  logic                     AXI_LITE_arvalid;
  logic                     AXI_LITE_arready;
  logic [AXI_LITE_DW-1:0]   AXI_LITE_rdata;
  logic [1:0]               AXI_LITE_rresp;
  logic                     AXI_LITE_rvalid;
  logic                     AXI_LITE_rready;

  modport slave (
    input  AXI_LITE_awaddr, AXI_LITE_awvalid, AXI_LITE_wdata, AXI_LITE_wstrb,
           AXI_LITE_wvalid, AXI_LITE_bready, AXI_LITE_araddr, AXI_LITE_arvalid,
           AXI_LITE_rready,
    output AXI_LITE_awready, AXI_LITE_wready, AXI_LITE_bresp, AXI_LITE_bvalid,
           AXI_LITE_arready, AXI_LITE_rdata, AXI_LITE_rresp, AXI_LITE_rvalid
  );

  modport master (
    output AXI_LITE_awaddr, AXI_LITE_awvalid, AXI_LITE_wdata, AXI_LITE_wstrb,
           AXI_LITE_wvalid, AXI_LITE_bready, AXI_LITE_araddr, AXI_LITE_arvalid,
           AXI_LITE_rready,
    input  AXI_LITE_awready, AXI_LITE_wready, AXI_LITE_bresp, AXI_LITE_bvalid,
           AXI_LITE_arready, AXI_LITE_rdata, AXI_LITE_rresp, AXI_LITE_rvalid
  );
endinterface

// File: rtl/srai_accel_ctrl_regs.sv
// AXI-Lite control/status register file for the SRAI HLS kernel.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   s_axil            : AXI-Lite slave (32-bit data, responses always OKAY)
//   ap_start          : kernel start (W1S, held until ap_ready, optional auto-restart)
//   ap_done/idle/ready: kernel block-level status
//   src_addr/dst_addr : buffer byte addresses (LO/HI register pairs)
//   xfer_len          : transfer length in bytes
//   interrupt         : level interrupt, GIE & |ISR, registered
// Map: 0x00 CTRL, 0x04 GIE, 0x08 IER, 0x0C ISR, 0x10/0x14 SRC, 0x18/0x1C DST, 0x20 LEN.
module srai_accel_ctrl_regs #(
  parameter int ADDR_DECODE_W = 6,
  parameter int ADDR_OUT_W    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  srai_accel_AXI_LITE_intfc.slave s_axil,
  output logic                  ap_start,
  input  logic                  ap_done,
  input  logic                  ap_idle,
  input  logic                  ap_ready,
  output logic [ADDR_OUT_W-1:0] src_addr,
  output logic [ADDR_OUT_W-1:0] dst_addr,
  output logic [31:0]           xfer_len,
  output logic                  interrupt
);
  localparam int IDX_W = ADDR_DECODE_W - 2;
  localparam bit HI_EN = (ADDR_OUT_W == 64);
  localparam logic [IDX_W-1:0] R_CTRL = IDX_W'(0), R_GIE = IDX_W'(1), R_IER = IDX_W'(2),
    R_ISR = IDX_W'(3), R_SRCL = IDX_W'(4), R_SRCH = IDX_W'(5), R_DSTL = IDX_W'(6),
    R_DSTH = IDX_W'(7), R_LEN = IDX_W'(8);

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = strb[b] ? nw[8*b +: 8] : old[8*b +: 8];
    return res;
  endfunction

  // Write channel state
  wr_state_e wr_state_q, wr_state_d;
  logic aw_lat_q, aw_lat_d, w_lat_q, w_lat_d;
  logic [IDX_W-1:0] awidx_q, awidx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic wr_fire;
  // Read channel state
  rd_state_e rd_state_q, rd_state_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d, rd_val;
  logic [IDX_W-1:0] rd_idx;
  logic ar_hs, ctrl_rd;
  // Registers
  logic start_q, start_d, done_q, done_d, ready_q, ready_d, auto_q, auto_d;
  logic gie_q, gie_d, int_q, int_d;
  logic [1:0] ier_q, ier_d, isr_q, isr_d;
  logic [31:0] srcl_q, srcl_d, srch_q, srch_d, dstl_q, dstl_d, dsth_q, dsth_d, len_q, len_d;

  // Upper address bits and byte-lane offset are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{s_axil.AXI_LITE_awaddr, s_axil.AXI_LITE_araddr};

  assign rd_idx  = s_axil.AXI_LITE_araddr[ADDR_DECODE_W-1:2];
  assign ar_hs   = (rd_state_q == RD_IDLE) && s_axil.AXI_LITE_arvalid && arready_q;
  assign ctrl_rd = ar_hs && (rd_idx == R_CTRL);

  // Read mux; sticky bits are ORed with a same-cycle pulse so the event is reported.
  always_comb begin
    rd_val = 32'h0;
    case (rd_idx)
      R_CTRL: rd_val = {24'h0, auto_q, 3'b000, ready_q | ap_ready, ap_idle, done_q | ap_done, start_q};
      R_GIE:  rd_val = {31'h0, gie_q};
      R_IER:  rd_val = {30'h0, ier_q};
      R_ISR:  rd_val = {30'h0, isr_q};
      R_SRCL: rd_val = srcl_q;
      R_SRCH: rd_val = HI_EN ? srch_q : 32'h0;
      R_DSTL: rd_val = dstl_q;
      R_DSTH: rd_val = HI_EN ? dsth_q : 32'h0;
      R_LEN:  rd_val = len_q;
      default: rd_val = 32'h0;
    endcase
  end

  // AW and W latch independently; the register update fires once both are held.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_lat_d = aw_lat_q;  w_lat_d = w_lat_q;
    awidx_d = awidx_q;  wdata_d = wdata_q;  wstrb_d = wstrb_q;
    bvalid_d = bvalid_q;
    wr_fire = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_lat_q && w_lat_q) begin
          wr_fire = 1'b1;
          aw_lat_d = 1'b0;  w_lat_d = 1'b0;
          bvalid_d = 1'b1;
          wr_state_d = WR_RESP;
        end else begin
          if (s_axil.AXI_LITE_awvalid && awready_q) begin
            aw_lat_d = 1'b1;
            awidx_d = s_axil.AXI_LITE_awaddr[ADDR_DECODE_W-1:2];
          end
          if (s_axil.AXI_LITE_wvalid && wready_q) begin
            w_lat_d = 1'b1;
            wdata_d = s_axil.AXI_LITE_wdata;
            wstrb_d = s_axil.AXI_LITE_wstrb;
          end
        end
      end
      WR_RESP: if (s_axil.AXI_LITE_bready) begin
        bvalid_d = 1'b0;
        wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
    awready_d = (wr_state_d == WR_IDLE) && !aw_lat_d;
    wready_d  = (wr_state_d == WR_IDLE) && !w_lat_d;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d = rvalid_q;
    rdata_d = rdata_q;
    case (rd_state_q)
      RD_IDLE: if (ar_hs) begin
        rdata_d = rd_val;
        rvalid_d = 1'b1;
        rd_state_d = RD_DATA;
      end
      RD_DATA: if (s_axil.AXI_LITE_rready) begin
        rvalid_d = 1'b0;
        rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
    arready_d = (rd_state_d == RD_IDLE);
  end

  // Register updates. Set events take priority over clears/toggles in the same cycle.
  always_comb begin
    logic b0;
    b0 = wstrb_q[0];
    start_d = start_q;
    if (ap_ready) start_d = 1'b0;
    if (auto_q && ap_done) start_d = 1'b1;
    if (wr_fire && awidx_q == R_CTRL && b0 && wdata_q[0]) start_d = 1'b1;
    done_d  = (done_q && !ctrl_rd) || ap_done;
    ready_d = (ready_q && !ctrl_rd) || ap_ready;
    auto_d = (wr_fire && awidx_q == R_CTRL && b0) ? wdata_q[7] : auto_q;
    gie_d  = (wr_fire && awidx_q == R_GIE && b0) ? wdata_q[0] : gie_q;
    ier_d  = (wr_fire && awidx_q == R_IER && b0) ? wdata_q[1:0] : ier_q;
    isr_d = isr_q;
    if (wr_fire && awidx_q == R_ISR && b0) isr_d = isr_q ^ wdata_q[1:0];
    if (ap_done && ier_q[0])  isr_d[0] = 1'b1;
    if (ap_ready && ier_q[1]) isr_d[1] = 1'b1;
    srcl_d = (wr_fire && awidx_q == R_SRCL) ? merge(srcl_q, wdata_q, wstrb_q) : srcl_q;
    srch_d = (wr_fire && awidx_q == R_SRCH) ? merge(srch_q, wdata_q, wstrb_q) : srch_q;
    dstl_d = (wr_fire && awidx_q == R_DSTL) ? merge(dstl_q, wdata_q, wstrb_q) : dstl_q;
    dsth_d = (wr_fire && awidx_q == R_DSTH) ? merge(dsth_q, wdata_q, wstrb_q) : dsth_q;
    len_d  = (wr_fire && awidx_q == R_LEN)  ? merge(len_q,  wdata_q, wstrb_q) : len_q;
    int_d = gie_q && (|isr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= WR_IDLE;  rd_state_q <= RD_IDLE;
      aw_lat_q <= 1'b0;  w_lat_q <= 1'b0;
      awidx_q <= '0;  wdata_q <= '0;  wstrb_q <= '0;
      awready_q <= 1'b0;  wready_q <= 1'b0;  bvalid_q <= 1'b0;
      arready_q <= 1'b0;  rvalid_q <= 1'b0;  rdata_q <= '0;
      start_q <= 1'b0;  done_q <= 1'b0;  ready_q <= 1'b0;  auto_q <= 1'b0;
      gie_q <= 1'b0;  ier_q <= '0;  isr_q <= '0;  int_q <= 1'b0;
      srcl_q <= '0;  srch_q <= '0;  dstl_q <= '0;  dsth_q <= '0;  len_q <= '0;
    end else begin
      wr_state_q <= wr_state_d;  rd_state_q <= rd_state_d;
      aw_lat_q <= aw_lat_d;  w_lat_q <= w_lat_d;
      awidx_q <= awidx_d;  wdata_q <= wdata_d;  wstrb_q <= wstrb_d;
      awready_q <= awready_d;  wready_q <= wready_d;  bvalid_q <= bvalid_d;
      arready_q <= arready_d;  rvalid_q <= rvalid_d;  rdata_q <= rdata_d;
      start_q <= start_d;  done_q <= done_d;  ready_q <= ready_d;  auto_q <= auto_d;
      gie_q <= gie_d;  ier_q <= ier_d;  isr_q <= isr_d;  int_q <= int_d;
      srcl_q <= srcl_d;  srch_q <= srch_d;  dstl_q <= dstl_d;  dsth_q <= dsth_d;  len_q <= len_d;
    end
  end

  logic [63:0] src_full, dst_full;
  assign src_full = {srch_q, srcl_q};
  assign dst_full = {dsth_q, dstl_q};
  assign src_addr = src_full[ADDR_OUT_W-1:0];
  assign dst_addr = dst_full[ADDR_OUT_W-1:0];
  assign xfer_len = len_q;
  assign ap_start = start_q;
  assign interrupt = int_q;

  assign s_axil.AXI_LITE_awready = awready_q;
  assign s_axil.AXI_LITE_wready  = wready_q;
  assign s_axil.AXI_LITE_bvalid  = bvalid_q;
  assign s_axil.AXI_LITE_bresp   = 2'b00;
  assign s_axil.AXI_LITE_arready = arready_q;
  assign s_axil.AXI_LITE_rvalid  = rvalid_q;
  assign s_axil.AXI_LITE_rdata   = rdata_q;
  assign s_axil.AXI_LITE_rresp   = 2'b00;
endmodule

// File: tb/tb_srai_accel_ctrl_regs.sv
module tb_srai_accel_ctrl_regs;
  logic clk = 1'b0;
  logic rst;
  logic ap_start, ap_done, ap_idle, ap_ready, interrupt;
  logic [63:0] src_addr, dst_addr;
  logic [31:0] xfer_len;
  int checks = 0, errors = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  srai_accel_AXI_LITE_intfc axil();

  srai_accel_ctrl_regs #(.ADDR_DECODE_W(6), .ADDR_OUT_W(64)) dut (
    .clk(clk), .rst(rst), .s_axil(axil), .ap_start(ap_start), .ap_done(ap_done),
    .ap_idle(ap_idle), .ap_ready(ap_ready), .src_addr(src_addr), .dst_addr(dst_addr),
    .xfer_len(xfer_len), .interrupt(interrupt)
  );

  always @(negedge clk) if (ap_start) start_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly, input string name);
    int cyc = 0, held = 0;
    bit aw_done = 0, w_done = 0, aw_hs, w_hs, bhs = 0;
    logic [1:0] resp = 2'b11;
    axil.AXI_LITE_awaddr = addr;
    axil.AXI_LITE_wdata = data;
    axil.AXI_LITE_wstrb = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      axil.AXI_LITE_awvalid = !aw_done && (cyc >= aw_dly);
      axil.AXI_LITE_wvalid  = !w_done && (cyc >= w_dly);
      @(negedge clk);
      aw_hs = axil.AXI_LITE_awvalid && axil.AXI_LITE_awready;
      w_hs  = axil.AXI_LITE_wvalid && axil.AXI_LITE_wready;
      tick();
      aw_done = aw_done | aw_hs;
      w_done  = w_done | w_hs;
      cyc++;
    end
    axil.AXI_LITE_awvalid = 1'b0;
    axil.AXI_LITE_wvalid = 1'b0;
    axil.AXI_LITE_bready = (b_dly == 0);
    cyc = 0;
    while (!bhs && cyc < 40) begin
      @(negedge clk);
      if (axil.AXI_LITE_bvalid) begin
        held++;
        resp = axil.AXI_LITE_bresp;
        bhs = axil.AXI_LITE_bready;
      end
      tick();
      axil.AXI_LITE_bready = (held >= b_dly);
      cyc++;
    end
    axil.AXI_LITE_bready = 1'b0;
    check({name, " b handshake"}, {62'h0, aw_done && w_done, bhs}, 64'h3);
    check({name, " bvalid cycles"}, held, b_dly + 1);
    check({name, " bresp"}, resp, 2'b00);
  endtask

  task automatic axi_read(input logic [31:0] addr, input bit done_at_hs, input string name,
                          output logic [31:0] data);
    int cyc = 0, lat = -1;
    bit hs = 0, got = 0;
    logic [1:0] resp = 2'b11;
    data = 32'hxxxxxxxx;
    axil.AXI_LITE_araddr = addr;
    axil.AXI_LITE_arvalid = 1'b1;
    while (!hs && cyc < 40) begin
      @(negedge clk);
      hs = axil.AXI_LITE_arready;
      if (hs && done_at_hs) ap_done = 1'b1;
      tick();
      ap_done = 1'b0;
      cyc++;
    end
    axil.AXI_LITE_arvalid = 1'b0;
    cyc = 0;
    while (hs && !got && cyc < 40) begin
      @(negedge clk);
      if (axil.AXI_LITE_rvalid) begin
        got = 1;
        lat = cyc;
        data = axil.AXI_LITE_rdata;
        resp = axil.AXI_LITE_rresp;
      end
      tick();
      cyc++;
    end
    check({name, " rvalid latency"}, lat, 0);
    check({name, " rresp"}, resp, 2'b00);
  endtask

  task automatic pulse_done();
    ap_done = 1'b1; tick(); ap_done = 1'b0;
  endtask

  task automatic pulse_ready();
    ap_ready = 1'b1; tick(); ap_ready = 1'b0;
  endtask

  function automatic logic [31:0] reg_mask(input logic [31:0] off);
    case (off)
      32'h04: return 32'h1;
      32'h08: return 32'h3;
      32'h10, 32'h14, 32'h18, 32'h1C, 32'h20: return 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    vec_t vecs[10];
    logic [31:0] rd;
    logic [31:0] mdl [16];
    logic [31:0] offs [9];
    int n;

    vecs[0] = '{32'h20, 32'h11223344, 4'hF, 1, 0, 32'h11223344};
    vecs[1] = '{32'h20, 32'hAABBCCDD, 4'h2, 0, 1, 32'h1122CC44};
    vecs[2] = '{32'h04, 32'hFFFFFFFF, 4'hF, 0, 0, 32'h00000001};
    vecs[3] = '{32'h08, 32'hFFFFFFFF, 4'hF, 2, 0, 32'h00000003};
    vecs[4] = '{32'h04, 32'h00000000, 4'hE, 0, 0, 32'h00000001};
    vecs[5] = '{32'h18, 32'hCAFEBABE, 4'hF, 0, 2, 32'hCAFEBABE};
    vecs[6] = '{32'h1C, 32'h12345678, 4'h9, 0, 0, 32'h12000078};
    vecs[7] = '{32'h3C, 32'hDEADBEEF, 4'hF, 0, 0, 32'h00000000};
    vecs[8] = '{32'h04, 32'h00000000, 4'hF, 0, 0, 32'h00000000};
    vecs[9] = '{32'h08, 32'h00000000, 4'h1, 0, 0, 32'h00000000};
    offs = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h3C};

    rst = 1'b1;
    ap_done = 0; ap_idle = 0; ap_ready = 0;
    axil.AXI_LITE_awaddr = 0; axil.AXI_LITE_awvalid = 0;
    axil.AXI_LITE_wdata = 0; axil.AXI_LITE_wstrb = 0; axil.AXI_LITE_wvalid = 0;
    axil.AXI_LITE_bready = 0; axil.AXI_LITE_araddr = 0; axil.AXI_LITE_arvalid = 0;
    axil.AXI_LITE_rready = 1;
    repeat (3) tick();

    // Reset state
    check("reset handshake outs", {axil.AXI_LITE_awready, axil.AXI_LITE_wready, axil.AXI_LITE_bvalid,
          axil.AXI_LITE_arready, axil.AXI_LITE_rvalid, axil.AXI_LITE_bresp, axil.AXI_LITE_rresp}, 0);
    check("reset rdata", axil.AXI_LITE_rdata, 0);
    check("reset kernel outs", {ap_start, interrupt}, 0);
    check("reset src/dst/len", src_addr | dst_addr | {32'h0, xfer_len}, 0);
    rst = 1'b0;
    tick();
    check("readies after reset", {axil.AXI_LITE_awready, axil.AXI_LITE_wready, axil.AXI_LITE_arready}, 3'b111);

    // AW three cycles ahead of W, bready held off for four cycles
    axi_write(32'h10, 32'h1000_0000, 4'hF, 0, 3, 4, "src_lo");
    axi_write(32'h14, 32'h0000_0001, 4'hF, 0, 3, 0, "src_hi");
    check("src_addr", src_addr, 64'h0000_0001_1000_0000);

    // Table-driven write/readback
    foreach (vecs[i]) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].aw_dly, vecs[i].w_dly, i % 3, "vec wr");
      axi_read(vecs[i].addr, 1'b0, "vec rd", rd);
      check($sformatf("vec[%0d] readback", i), rd, vecs[i].exp);
    end
    check("dst_addr", dst_addr, 64'h12000078_CAFEBABE);
    check("xfer_len", xfer_len, 32'h1122CC44);

    // Read handshake in the same cycle as a write update returns the old value
    n = 0;
    while (!(axil.AXI_LITE_awready && axil.AXI_LITE_wready && axil.AXI_LITE_arready) && n < 20) begin
      tick(); n++;
    end
    axil.AXI_LITE_awaddr = 32'h20; axil.AXI_LITE_wdata = 32'h55667788; axil.AXI_LITE_wstrb = 4'hF;
    axil.AXI_LITE_awvalid = 1; axil.AXI_LITE_wvalid = 1;
    tick();
    axil.AXI_LITE_awvalid = 0; axil.AXI_LITE_wvalid = 0;
    axil.AXI_LITE_araddr = 32'h20; axil.AXI_LITE_arvalid = 1; axil.AXI_LITE_bready = 1;
    tick();
    axil.AXI_LITE_arvalid = 0;
    @(negedge clk);
    check("rw collide rvalid/bvalid", {axil.AXI_LITE_rvalid, axil.AXI_LITE_bvalid}, 2'b11);
    check("rw collide rdata pre-write", axil.AXI_LITE_rdata, 32'h1122CC44);
    tick();
    axil.AXI_LITE_bready = 0;
    axi_read(32'h20, 1'b0, "len after collide", rd);
    check("len after collide", rd, 32'h55667788);

    // ap_start held until the ap_ready cycle: 6 cycles when ready arrives in cycle 6
    ap_idle = 1'b1;
    start_cnt = 0;
    axi_write(32'h00, 32'h1, 4'hF, 0, 0, 0, "ctrl start");
    n = 0;
    while (start_cnt < 5 && n < 20) begin tick(); n++; end
    pulse_ready();
    check("ap_start cleared after ready", ap_start, 0);
    repeat (4) tick();
    check("ap_start high cycles", start_cnt, 6);
    pulse_done();
    axi_read(32'h00, 1'b0, "ctrl rd1", rd);
    check("ctrl after done", rd, 32'h0000000E);
    axi_read(32'h00, 1'b0, "ctrl rd2", rd);
    check("ctrl cleared on read", rd, 32'h00000004);

    // Interrupt path
    axi_write(32'h04, 32'h1, 4'hF, 0, 0, 0, "gie");
    axi_write(32'h08, 32'h1, 4'hF, 0, 0, 0, "ier");
    pulse_done();
    check("interrupt lags isr", interrupt, 0);
    tick();
    check("interrupt asserted", interrupt, 1);
    axi_read(32'h0C, 1'b0, "isr rd", rd);
    check("isr done bit", rd, 32'h1);
    axi_write(32'h0C, 32'h1, 4'hF, 0, 0, 0, "isr toggle");
    check("interrupt after isr clear", interrupt, 0);
    axi_read(32'h0C, 1'b0, "isr rd2", rd);
    check("isr cleared", rd, 32'h0);
    axi_write(32'h08, 32'h0, 4'hF, 0, 0, 0, "ier off");
    pulse_done();
    repeat (3) tick();
    check("interrupt masked by ier", interrupt, 0);

    // Clear-on-read racing a done pulse
    axi_read(32'h00, 1'b0, "ctrl pre", rd);
    check("ctrl pre-race", rd, 32'h00000006);
    axi_read(32'h00, 1'b1, "ctrl race", rd);
    check("ctrl race returns done", rd, 32'h00000006);
    axi_read(32'h00, 1'b0, "ctrl post", rd);
    check("ctrl done kept", rd, 32'h00000006);
    axi_read(32'h00, 1'b0, "ctrl post2", rd);
    check("ctrl done cleared", rd, 32'h00000004);

    // Auto-restart
    axi_write(32'h00, 32'h81, 4'hF, 0, 0, 0, "ctrl auto");
    check("auto start", ap_start, 1);
    for (int k = 0; k < 3; k++) begin
      pulse_ready();
      check($sformatf("auto ready clr %0d", k), ap_start, 0);
      pulse_done();
      check($sformatf("auto restart %0d", k), ap_start, 1);
    end
    axi_write(32'h00, 32'h00, 4'hF, 0, 0, 0, "ctrl auto off");
    check("write 0 keeps start", ap_start, 1);
    pulse_ready();
    pulse_done();
    check("no restart after auto off", ap_start, 0);

    // Reset between AW and W
    axil.AXI_LITE_awaddr = 32'h20; axil.AXI_LITE_awvalid = 1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (axil.AXI_LITE_awready) n = 100; else n++;
      tick();
    end
    axil.AXI_LITE_awvalid = 0;
    check("aw accepted before reset", n, 100);
    rst = 1; tick(); tick(); rst = 0;
    n = 0;
    for (int k = 0; k < 5; k++) begin @(negedge clk); n += int'(axil.AXI_LITE_bvalid); tick(); end
    check("no bvalid after reset", n, 0);
    axi_read(32'h20, 1'b0, "len after reset", rd);
    check("len after reset", rd, 32'h0);

    // Reset landing on the update cycle
    axil.AXI_LITE_awaddr = 32'h20; axil.AXI_LITE_wdata = 32'hCAFEF00D; axil.AXI_LITE_wstrb = 4'hF;
    axil.AXI_LITE_awvalid = 1; axil.AXI_LITE_wvalid = 1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (axil.AXI_LITE_awready && axil.AXI_LITE_wready) n = 100; else n++;
      tick();
    end
    axil.AXI_LITE_awvalid = 0; axil.AXI_LITE_wvalid = 0;
    rst = 1; tick(); rst = 0;
    n = 0;
    for (int k = 0; k < 4; k++) begin @(negedge clk); n += int'(axil.AXI_LITE_bvalid); tick(); end
    check("no bvalid on reset update", n, 0);
    axi_read(32'h20, 1'b0, "len after reset2", rd);
    check("len not updated", rd, 32'h0);

    // Random traffic against a byte-lane register model
    foreach (mdl[i]) mdl[i] = 32'h0;
    for (int it = 0; it < 40; it++) begin
      logic [31:0] off, data, m;
      logic [3:0] strb;
      off = offs[$urandom_range(0, 8)];
      ap_idle = 1'($urandom_range(0, 1));
      if (off != 0 && $urandom_range(0, 1) == 1) begin
        data = $urandom;
        strb = 4'($urandom_range(0, 15));
        axi_write(off, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), "rand wr");
        m = mdl[off[5:2]];
        for (int b = 0; b < 4; b++) if (strb[b]) m[8*b +: 8] = data[8*b +: 8];
        mdl[off[5:2]] = m & reg_mask(off);
      end else begin
        axi_read(off, 1'b0, "rand rd", rd);
        if (off == 0) check($sformatf("rand ctrl it%0d", it), rd, {29'h0, ap_idle, 2'b00});
        else check($sformatf("rand rd %0h it%0d", off, it), rd, mdl[off[5:2]]);
      end
    end
    check("rand src_addr", src_addr, {mdl[5], mdl[4]});
    check("rand dst_addr", dst_addr, {mdl[7], mdl[6]});
    check("rand xfer_len", xfer_len, mdl[8]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/srai_accel_ctrl_regs.md
Name: srai_accel_ctrl_regs

Overview:
- AXI-Lite slave control/status register file that terminates the host-side AXI-Lite interface (slave modport of srai_accel_AXI_LITE_intfc).
- Drives the HLS kernel block-level handshake (ap_start/ap_done/ap_idle/ap_ready).
- Exports the source/destination buffer addresses and transfer length consumed by the kernel's AXI-MM master.
- Raises a level interrupt on kernel completion.

Parameters:
- ADDR_DECODE_W, 6, number of low AXI_LITE_araddr/awaddr bits decoded; upper bits are ignored.
- ADDR_OUT_W, 64, width of src_addr/dst_addr outputs; must be 64 or 32 (32 makes the HI registers read 0).

Ports:
- clk  in  1  kernel/AXI clock.
- rst  in  1  synchronous, active-high reset.
- s_axil  slave modport  srai_accel_AXI_LITE_intfc  host register access; data width is AXI_LITE_DW = 32.
- ap_start  out  1  kernel start.
- ap_done  in  1  kernel done pulse.
- ap_idle  in  1  kernel idle level.
- ap_ready  in  1  kernel ready-for-next-start pulse.
- src_addr  out  ADDR_OUT_W  source buffer byte address.
- dst_addr  out  ADDR_OUT_W  destination buffer byte address.
- xfer_len  out  32  transfer length in bytes.
- interrupt  out  1  level interrupt to host.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values:
  - All registers 0; ap_start=0; interrupt=0.
  - awready=0, wready=0, bvalid=0, arready=0, rvalid=0; rdata=0; bresp=rresp=2'b00.
- Register map (byte offsets):
  - 0x00 CTRL:
    - bit0 ap_start (W1S).
    - bit1 done (RO, sticky, clear-on-read).
    - bit2 ap_idle (RO, live).
    - bit3 ready (RO, sticky, clear-on-read).
    - bit7 auto_restart (RW).
  - 0x04 GIE: bit0 (RW).
  - 0x08 IER: bit0 done enable, bit1 ready enable (RW).
  - 0x0C ISR: bit0 done, bit1 ready (W1 toggles).
  - 0x10 SRC_LO, 0x14 SRC_HI, 0x18 DST_LO, 0x1C DST_HI, 0x20 LEN: all RW.
  - Unmapped offsets: writes dropped, reads return 0; response is always OKAY.
- Write channel, two-state FSM WR_IDLE → WR_RESP:
  - In WR_IDLE, awready and wready are both high when no address/data is latched.
  - AW and W may arrive in either order or in the same cycle; each is latched independently and its ready drops once latched.
  - Register update occurs in the cycle after both are latched. bvalid rises in that same cycle and holds until bready; then back to WR_IDLE with readies high the next cycle.
  - No new AW/W is accepted while bvalid=1.
- wstrb: applied per byte on RW registers; ignored on CTRL/ISR single-bit fields except byte 0 gates them.
- Read channel, two states RD_IDLE → RD_DATA:
  - arready=1 in RD_IDLE.
  - On arvalid&arready, rdata is registered and rvalid asserts the next cycle, held until rready.
  - arready=0 while rvalid=1.
- Clear-on-read (CTRL done/ready): clears in the cycle the AR handshake occurs. A done/ready pulse in that same cycle wins: the bit stays 1 (event not lost), and the returned value reflects the pre-clear value OR the new pulse.
- ap_start:
  - Set by a write of 1 to CTRL bit0.
  - Held until a cycle with ap_ready=1, then cleared the following cycle.
  - If auto_restart=1 it is re-asserted immediately on ap_done.
  - Writing 0 has no effect.
- ISR bits set on ap_done/ap_ready pulses when the matching IER bit is 1.
  - If a W1 toggle and a set event occur in the same cycle, the set wins.
- interrupt = GIE & |(ISR), registered (1-cycle latency from the ISR change).
- Reset mid-transaction aborts the in-flight write/read: no bvalid/rvalid after reset, and the register update is not performed if reset coincides with the update cycle.
- Simultaneous read and write to the same register: the read returns the pre-write value.

Test Plan:
- Write SRC_LO=0x1000_0000, SRC_HI=0x0000_0001 with AW 3 cycles before W → src_addr=0x0000_0001_1000_0000; bresp=OKAY; bvalid held 4 cycles while bready=0.
- Write CTRL=0x1; ap_ready pulses 5 cycles later → ap_start high for exactly 6 cycles. Then ap_done pulse → CTRL read returns bit1=1; a second read returns bit1=0.
- GIE=1, IER=0x1, ap_done pulse → interrupt=1 one cycle after ISR=0x1. Write ISR=0x1 → interrupt=0. With IER=0, a done pulse leaves interrupt=0.
- CTRL read handshake coincident with an ap_done pulse → returned bit1=1 and CTRL bit1 still reads 1 on the next read.
- auto_restart=1, start once, three ap_done pulses → ap_start re-asserts after each pulse; clearing auto_restart stops re-assertion.
- Write wstrb=4'b0010 data=0xAABBCCDD to LEN (prior 0x11223344) → LEN=0x1122CC44. Read of offset 0x3C → 0 with OKAY. Reset asserted between AW and W → no bvalid, LEN unchanged from reset.
